// File: rtl/portal_indication_arbiter.sv
// Multiplexes several indication sources onto one portal indication port:
// per-channel FIFOs feed a single head register through a round-robin scheduler.
module portal_indication_arbiter #(
    parameter int unsigned NUM_CHAN   = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NUM_CHAN-1:0]            EN_chan_enq,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0] chan_enq_v,
    output logic [NUM_CHAN-1:0]            RDY_chan_enq,
    input  logic                           EN_indications_0_deq,
    output logic                           RDY_indications_0_deq,
    output logic                           RDY_indications_0_notEmpty,
    output logic                           indications_0_notEmpty,
    output logic                           RDY_indications_0_first,
    output logic [DATA_WIDTH-1:0]          indications_0_first,
    output logic                           RDY_intr_status,
    output logic                           intr_status,
    output logic                           RDY_intr_channel,
    output logic [31:0]                    intr_channel,
    input  logic                           EN_intr_enable,
    input  logic                           intr_enable_v
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned GW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [GW-1:0] LAST_CH  = GW'(NUM_CHAN - 1);

    logic [DATA_WIDTH-1:0] mem    [NUM_CHAN][DEPTH];
    logic [PW-1:0]         wr_ptr [NUM_CHAN];
    logic [PW-1:0]         rd_ptr [NUM_CHAN];
    logic [CW-1:0]         count  [NUM_CHAN];

    logic [NUM_CHAN-1:0]   not_full;
    logic [NUM_CHAN-1:0]   not_empty;
    logic [NUM_CHAN-1:0]   enq_ok;
    logic [NUM_CHAN-1:0]   pop;

    logic                  head_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic [GW-1:0]         head_chan;
    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         grant;
    logic [GW-1:0]         cand;
    logic                  grant_found;
    logic                  load;
    logic                  deq_ok;
    logic                  intr_en_q;
    logic [DATA_WIDTH-1:0] grant_data;

    // Full/empty come from registered counts only, so no EN input reaches a RDY output.
    always_comb begin
        not_full  = '0;
        not_empty = '0;
        enq_ok    = '0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            not_full[i]  = (count[i] != FULL_CNT);
            not_empty[i] = (count[i] != '0);
            enq_ok[i]    = EN_chan_enq[i] && not_full[i];
        end
    end

    // Scan last_grant+1, last_grant+2, ... wrapping; first non-empty channel wins.
    always_comb begin
        grant       = '0;
        cand        = '0;
        grant_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_CHAN; k++) begin
            cand = GW'((32'(last_grant) + k) % NUM_CHAN);
            if (!grant_found && not_empty[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        deq_ok     = EN_indications_0_deq && head_valid;
        load       = (!head_valid || deq_ok) && grant_found;
        grant_data = mem[grant][rd_ptr[grant]];
        pop        = '0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            pop[i] = load && (grant == GW'(i));
        end
    end

    // Storage array carries no reset; emptiness is defined by the counts.
    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            if (enq_ok[i]) begin
                mem[i][wr_ptr[i]] <= chan_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NUM_CHAN; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CHAN; i++) begin
                if (enq_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({enq_ok[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Head refills on the same edge it is dequeued, giving one word per cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            head_chan  <= '0;
            last_grant <= LAST_CH;
        end else if (load) begin
            head_valid <= 1'b1;
            head_data  <= grant_data;
            head_chan  <= grant;
            last_grant <= grant;
        end else if (deq_ok) begin
            head_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            intr_en_q <= 1'b0;
        end else if (EN_intr_enable) begin
            intr_en_q <= intr_enable_v;
        end
    end

    assign RDY_chan_enq               = not_full;
    assign RDY_indications_0_deq      = head_valid;
    assign RDY_indications_0_notEmpty = 1'b1;
    assign indications_0_notEmpty     = head_valid;
    assign RDY_indications_0_first    = head_valid;
    assign indications_0_first        = head_data;
    assign RDY_intr_status            = 1'b1;
    assign intr_status                = head_valid && intr_en_q;
    assign RDY_intr_channel           = 1'b1;
    assign intr_channel               = head_valid ? 32'(head_chan) : '1;

endmodule

// File: tb/tb_portal_indication_arbiter.sv
// Scoreboard bench for portal_indication_arbiter: stimulus pushes expected head words,
// a negedge monitor pops and compares them on every host dequeue.
module tb_portal_indication_arbiter;

    logic        CLK;
    logic        RST_N;
    logic [1:0]  EN_chan_enq;
    logic [63:0] chan_enq_v;
    logic [1:0]  RDY_chan_enq;
    logic        EN_indications_0_deq;
    logic        RDY_indications_0_deq;
    logic        RDY_indications_0_notEmpty;
    logic        indications_0_notEmpty;
    logic        RDY_indications_0_first;
    logic [31:0] indications_0_first;
    logic        RDY_intr_status;
    logic        intr_status;
    logic        RDY_intr_channel;
    logic [31:0] intr_channel;
    logic        EN_intr_enable;
    logic        intr_enable_v;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    portal_indication_arbiter #(
        .NUM_CHAN   (2),
        .DEPTH      (4),
        .DATA_WIDTH (32)
    ) dut (
        .CLK                        (CLK),
        .RST_N                      (RST_N),
        .EN_chan_enq                (EN_chan_enq),
        .chan_enq_v                 (chan_enq_v),
        .RDY_chan_enq               (RDY_chan_enq),
        .EN_indications_0_deq       (EN_indications_0_deq),
        .RDY_indications_0_deq      (RDY_indications_0_deq),
        .RDY_indications_0_notEmpty (RDY_indications_0_notEmpty),
        .indications_0_notEmpty     (indications_0_notEmpty),
        .RDY_indications_0_first    (RDY_indications_0_first),
        .indications_0_first        (indications_0_first),
        .RDY_intr_status            (RDY_intr_status),
        .intr_status                (intr_status),
        .RDY_intr_channel           (RDY_intr_channel),
        .intr_channel               (intr_channel),
        .EN_intr_enable             (EN_intr_enable),
        .intr_enable_v              (intr_enable_v)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic enq(input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1);
        EN_chan_enq = en;
        chan_enq_v  = {d1, d0};
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_notEmpty"}, 32'(indications_0_notEmpty), 32'd0);
        chk({tag, "_intr_channel"}, intr_channel, 32'hFFFF_FFFF);
        chk({tag, "_rdy_enq"}, 32'(RDY_chan_enq), 32'd3);
        chk({tag, "_intr_status"}, 32'(intr_status), 32'd0);
        chk({tag, "_first"}, indications_0_first, 32'd0);
    endtask

    // Monitor: each host dequeue consumes the oldest expected word.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N && EN_indications_0_deq && indications_0_notEmpty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %h expected no word", indications_0_first);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("sb_word", indications_0_first, exp_w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        RST_N = 1'b0;
        enq(2'b00, 32'd0, 32'd0);
        EN_indications_0_deq = 1'b0;
        EN_intr_enable = 1'b0;
        intr_enable_v  = 1'b0;
        repeat (3) step();
        RST_N = 1'b1;
        chk_reset_outputs("rst");

        // Latency: one word on channel 1 reaches the head two edges later.
        enq(2'b10, 32'd0, 32'h0000_002A);
        step();
        enq(2'b00, 32'd0, 32'd0);
        chk("lat_before", 32'(indications_0_notEmpty), 32'd0);
        step();
        chk("lat_notEmpty", 32'(indications_0_notEmpty), 32'd1);
        chk("lat_first", indications_0_first, 32'h0000_002A);
        chk("lat_intr_channel", intr_channel, 32'd1);
        chk("lat_intr_off", 32'(intr_status), 32'd0);
        EN_intr_enable = 1'b1;
        intr_enable_v  = 1'b1;
        step();
        EN_intr_enable = 1'b0;
        chk("lat_intr_on", 32'(intr_status), 32'd1);
        exp_q.push_back(32'h0000_002A);
        EN_indications_0_deq = 1'b1;
        step();
        EN_indications_0_deq = 1'b0;
        chk("lat_drained", 32'(indications_0_notEmpty), 32'd0);

        // Round-robin: A0,B0,A1,B1 one per cycle.
        exp_q.push_back(32'hA000_0000);
        exp_q.push_back(32'hB000_0000);
        exp_q.push_back(32'hA000_0001);
        exp_q.push_back(32'hB000_0001);
        enq(2'b11, 32'hA000_0000, 32'hB000_0000);
        step();
        enq(2'b11, 32'hA000_0001, 32'hB000_0001);
        step();
        enq(2'b00, 32'd0, 32'd0);
        chk("rr_first_chan", intr_channel, 32'd0);
        EN_indications_0_deq = 1'b1;
        repeat (4) step();
        EN_indications_0_deq = 1'b0;
        chk("rr_empty", 32'(indications_0_notEmpty), 32'd0);

        // Full: head holds D0 from channel 1, channel 0 fills with C0..C3, C4 dropped.
        exp_q.push_back(32'hD000_0000);
        enq(2'b10, 32'd0, 32'hD000_0000);
        step();
        enq(2'b00, 32'd0, 32'd0);
        step();
        chk("full_head", indications_0_first, 32'hD000_0000);
        for (int k = 0; k < 5; k++) begin
            enq(2'b01, 32'hC000_0000 + 32'(k), 32'd0);
            step();
            if (k == 2) chk("full_rdy_3", 32'(RDY_chan_enq[0]), 32'd1);
            if (k == 3) chk("full_rdy_4", 32'(RDY_chan_enq[0]), 32'd0);
        end
        chk("full_rdy_5", 32'(RDY_chan_enq[0]), 32'd0);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'hC000_0000 + 32'(k));

        // Simultaneous: deq + enq on full channel 0; enqueue must be rejected.
        enq(2'b01, 32'hE000_0000, 32'd0);
        EN_indications_0_deq = 1'b1;
        step();
        enq(2'b00, 32'd0, 32'd0);
        EN_indications_0_deq = 1'b0;
        chk("sim_head", indications_0_first, 32'hC000_0000);
        chk("sim_chan", intr_channel, 32'd0);
        chk("sim_rdy", 32'(RDY_chan_enq), 32'd3);
        EN_indications_0_deq = 1'b1;
        repeat (4) step();
        EN_indications_0_deq = 1'b0;
        chk("sim_empty", 32'(indications_0_notEmpty), 32'd0);

        // Stability: head F0 held 10 cycles while both channels enqueue.
        exp_q.push_back(32'hF000_0000);
        enq(2'b10, 32'd0, 32'hF000_0000);
        step();
        enq(2'b00, 32'd0, 32'd0);
        step();
        for (int k = 0; k < 10; k++) begin
            enq(2'b11, 32'h0600_0000 + 32'(k), 32'h1600_0000 + 32'(k));
            step();
            chk("stab_first", indications_0_first, 32'hF000_0000);
            chk("stab_chan", intr_channel, 32'd1);
        end
        enq(2'b00, 32'd0, 32'd0);
        chk("stab_intr", 32'(intr_status), 32'd1);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(32'h0600_0000 + 32'(k));
            exp_q.push_back(32'h1600_0000 + 32'(k));
        end
        EN_indications_0_deq = 1'b1;
        repeat (9) step();
        EN_indications_0_deq = 1'b0;
        chk("stab_empty", 32'(indications_0_notEmpty), 32'd0);

        // Asynchronous reset mid-stream discards head and FIFO contents.
        enq(2'b11, 32'h7000_0000, 32'h7100_0000);
        step();
        enq(2'b11, 32'h7000_0001, 32'h7100_0001);
        step();
        enq(2'b00, 32'd0, 32'd0);
        chk("mid_busy", 32'(indications_0_notEmpty), 32'd1);
        #3;
        RST_N = 1'b0;
        #1;
        chk("mid_async_notEmpty", 32'(indications_0_notEmpty), 32'd0);
        chk("mid_async_chan", intr_channel, 32'hFFFF_FFFF);
        step();
        step();
        RST_N = 1'b1;
        chk_reset_outputs("mid");
        exp_q.push_back(32'h8000_0000);
        enq(2'b01, 32'h8000_0000, 32'd0);
        step();
        enq(2'b00, 32'd0, 32'd0);
        step();
        chk("post_rst_chan", intr_channel, 32'd0);
        EN_indications_0_deq = 1'b1;
        step();
        EN_indications_0_deq = 1'b0;
        step();
        chk("post_rst_empty", 32'(indications_0_notEmpty), 32'd0);

        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/portal_indication_arbiter.md
# portal_indication_arbiter

Shares one portal indication output port between several indication sources. Each source pushes 32-bit indication words into its own small FIFO. A round-robin scheduler moves words into a single output head register, which presents the standard deq/notEmpty/first/intr_status/intr_channel methods to the host-side portal. It sits between the user cores (Echo's `heard` path and siblings) and the portal wrapper, and replaces per-core indication-output instances.

## Interface
Parameters:
- NUM_CHAN, 2, number of indication sources (1..4)
- DEPTH, 4, per-channel FIFO depth (power of 2, 2..16)
- DATA_WIDTH, 32, indication word width

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- EN_chan_enq  in  NUM_CHAN  per-channel enqueue strobe
- chan_enq_v  in  NUM_CHAN*DATA_WIDTH  per-channel data, channel i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- RDY_chan_enq  out  NUM_CHAN  per-channel FIFO not full
- EN_indications_0_deq  in  1  host pops head word
- RDY_indications_0_deq  out  1  head valid
- RDY_indications_0_notEmpty  out  1  constant 1
- indications_0_notEmpty  out  1  head valid
- RDY_indications_0_first  out  1  head valid
- indications_0_first  out  DATA_WIDTH  head word
- RDY_intr_status  out  1  constant 1
- intr_status  out  1  head valid AND intr_enable
- RDY_intr_channel  out  1  constant 1
- intr_channel  out  32  head channel index, zero-extended; 32'hFFFF_FFFF when head empty
- EN_intr_enable  in  1  write interrupt enable
- intr_enable_v  in  1  new interrupt enable value

## Operation
- Per-channel FIFO: circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits) and a count of log2(DEPTH)+1 bits. RDY_chan_enq[i] = count_i != DEPTH.
- An enqueue with RDY low is ignored: no state change and no overwrite. Same-cycle enqueue and scheduler pop on one FIFO: count unchanged, both pointers advance.
- Head register: head_valid, head_data, head_chan.
- Load condition: load = (!head_valid || (EN_indications_0_deq && head_valid)) && any FIFO non-empty.
- Round-robin grant: the first non-empty channel scanning last_grant+1, last_grant+2, ... and wrapping modulo NUM_CHAN.
- On load: pop the granted FIFO into the head register and set last_grant to the granted channel.
- A deq without load clears head_valid. A deq with head_valid low is ignored.
- Head contents are stable while head_valid=1 and no deq occurs.
- intr_enable register: written when EN_intr_enable=1.
- Reset values:
  - all counts and pointers 0
  - head_valid=0, head_data=0, head_chan=0
  - last_grant=NUM_CHAN-1, so channel 0 wins first
  - intr_enable=0
  - outputs after reset: RDY_chan_enq all 1, notEmpty 0, first 0, intr_status 0, intr_channel 32'hFFFF_FFFF
- Reset asserted mid-operation discards all queued and head data immediately (asynchronous).

## Timing
- Enqueue at edge t into an empty system: the word is in the FIFO after t, loads into head at edge t+1, and notEmpty/first are valid after t+1. Latency is 2 edges.
- Back-to-back throughput: with deq held high and data available, one word per cycle. The head refills on the same edge it is dequeued.
- RDY_chan_enq reflects the registered count. A FIFO full at the start of a cycle rejects enqueue even if popped that same cycle.
- intr_status and intr_channel are combinational from registered state only. No combinational path exists from any EN input to any RDY output.
- Fairness: while all channels stay non-empty, grants rotate 0,1,...,NUM_CHAN-1,0. No channel waits more than NUM_CHAN-1 loads.

## Test plan
- Reset: hold RST_N=0 mid-stream with FIFOs partially full, then release. Required: notEmpty=0, intr_channel=32'hFFFF_FFFF, RDY_chan_enq=2'b11, intr_status=0.
- Latency: enqueue 32'h0000_002A on channel 1 at cycle 0 with channel 0 idle. Required: first=32'h2A, intr_channel=1, notEmpty=1 after edge 1 and not before; intr_status=1 only after EN_intr_enable with v=1.
- Round-robin: preload channel 0 with A0,A1 and channel 1 with B0,B1 (32'hA0.., 32'hB0..), then hold deq high. Required order A0,B0,A1,B1, one per cycle, then notEmpty=0.
- Full/backpressure: with DEPTH=4, enqueue 5 words on channel 0 with deq low. Required: RDY_chan_enq[0]=0 after the 4th word is accepted. The 5th word is dropped, and the drained sequence is exactly the first 4 words.
- Simultaneous events: with channel 0 full and the head valid, assert deq and enq on channel 0 in the same cycle. Required: enqueue rejected, the head reloads from channel 0, and the count becomes 3 next cycle.
- Stability: with the head valid and deq low for 10 cycles while both channels enqueue, first and intr_channel remain unchanged.
